// File: rtl/mult_div_unit.sv
// Multicycle unsigned multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, one op in flight.
module mult_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Flush,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             DivByZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;

  logic accept;
  logic div_zero;
  logic last_iter;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH:0]   div_hi_n;
  logic [WIDTH-1:0] div_lo_n;
  logic [WIDTH:0]   hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] result_n;

  assign accept    = (state_q == S_IDLE) && Start && !Flush;
  assign div_zero  = accept && Op[1] && (OpB == '0);
  assign last_iter = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: non-blocking (<=) for all registered state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        Busy = Start && !Flush;
        if (accept) begin
          state_d = div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        Busy = 1'b1;
        if (Flush) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shared datapath: hi_q is the product upper half (top bit always 0) or the
  // partial remainder; lo_q holds the multiplier or the dividend/quotient.
  always_comb begin
    mul_sum  = hi_q + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi_n = {1'b0, mul_sum[WIDTH:1]};
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift - {1'b0, b_q};
    div_hi_n  = div_ok ? div_diff : div_shift;
    div_lo_n  = {lo_q[WIDTH-2:0], div_ok};

    hi_n = op_q[1] ? div_hi_n : mul_hi_n;
    lo_n = op_q[1] ? div_lo_n : mul_lo_n;

    // MULH and REM take the high register, MUL and DIV the low one.
    result_n = op_q[0] ? hi_n[WIDTH-1:0] : lo_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      Result    <= '0;
      DivByZero <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      op_q  <= Op;
      a_q   <= OpA;
      b_q   <= OpB;
      hi_q  <= '0;
      lo_q  <= Op[1] ? OpA : OpB;
      if (div_zero) begin
        Result    <= Op[0] ? OpA : '1;
        DivByZero <= 1'b1;
      end
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (last_iter && !Flush) begin
        Result    <= result_n;
        DivByZero <= 1'b0;
      end
    end
  end

endmodule
